// File: rtl/ball_motion.sv
// ball_motion: pong ball-position engine, one move per rising edge of the divider tick.
// Optional feature macro BALL_MOTION_PAUSE_EN adds a pause input that freezes play.
module ball_motion #(
  parameter int XBITS       = 5,
  parameter int YBITS       = 4,
  parameter int PADDLE_H    = 3,
  parameter int SERVE_DELAY = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic [YBITS-1:0] paddle_l,
  input  logic [YBITS-1:0] paddle_r,
`ifdef BALL_MOTION_PAUSE_EN
  input  logic             pause,
`endif
  output logic [XBITS-1:0] ball_x,
  output logic [YBITS-1:0] ball_y,
  output logic             dir_x,
  output logic             dir_y,
  output logic             score_l,
  output logic             score_r
);

  localparam int CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [XBITS-1:0] X_MAX      = '1;
  localparam logic [XBITS-1:0] X_CTR      = XBITS'(1 << (XBITS - 1));
  localparam logic [YBITS-1:0] Y_MAX      = '1;
  localparam logic [YBITS-1:0] Y_CTR      = YBITS'(1 << (YBITS - 1));
  localparam logic [CW-1:0]    SERVE_LAST = CW'(SERVE_DELAY - 1);
  localparam logic [YBITS:0]   PH         = (YBITS + 1)'(PADDLE_H);

  typedef enum logic [1:0] {SERVE, PLAY, MISS} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    serve_cnt, serve_cnt_nx;
  logic             tick_prev, step, act;
  logic [XBITS-1:0] x_nx;
  logic [YBITS-1:0] y_nx;
  logic             dx_nx, dy_nx, sl_nx, sr_nx;
  logic [YBITS:0]   y_ext, pl_ext, pr_ext;
  logic             hit_l, hit_r;

  assign step = tick_in & ~tick_prev;
`ifdef BALL_MOTION_PAUSE_EN
  assign act = step & ~pause;
`else
  assign act = step;
`endif

  // One extra bit so a paddle near the bottom wall does not wrap its extent.
  assign y_ext  = {1'b0, ball_y};
  assign pl_ext = {1'b0, paddle_l};
  assign pr_ext = {1'b0, paddle_r};
  assign hit_l  = (y_ext >= pl_ext) && (y_ext < pl_ext + PH);
  assign hit_r  = (y_ext >= pr_ext) && (y_ext < pr_ext + PH);

  always_comb begin
    state_nx     = state;
    serve_cnt_nx = serve_cnt;
    x_nx         = ball_x;
    y_nx         = ball_y;
    dx_nx        = dir_x;
    dy_nx        = dir_y;
    sl_nx        = 1'b0;
    sr_nx        = 1'b0;
    if (act) begin
      case (state)
        SERVE: begin
          serve_cnt_nx = serve_cnt + 1'b1;
          if (serve_cnt == SERVE_LAST) state_nx = PLAY;
        end
        PLAY: begin
          if (dir_y) begin
            if (ball_y == Y_MAX) begin
              dy_nx = 1'b0;
              y_nx  = Y_MAX - 1'b1;
            end else begin
              y_nx  = ball_y + 1'b1;
            end
          end else begin
            if (ball_y == '0) begin
              dy_nx = 1'b1;
              y_nx  = YBITS'(1);
            end else begin
              y_nx  = ball_y - 1'b1;
            end
          end

          if (!dir_x && ball_x == XBITS'(1)) begin
            if (hit_l) begin
              dx_nx = 1'b1;
              x_nx  = XBITS'(2);
            end else begin
              x_nx     = '0;
              sr_nx    = 1'b1;
              state_nx = MISS;
            end
          end else if (dir_x && ball_x == X_MAX - 1'b1) begin
            if (hit_r) begin
              dx_nx = 1'b0;
              x_nx  = X_MAX - XBITS'(2);
            end else begin
              x_nx     = X_MAX;
              sl_nx    = 1'b1;
              state_nx = MISS;
            end
          end else begin
            x_nx = dir_x ? ball_x + 1'b1 : ball_x - 1'b1;
          end
        end
        MISS: begin
          // Serve toward whoever conceded: ball parked at column 0 means left lost.
          dx_nx        = (ball_x != '0);
          x_nx         = X_CTR;
          y_nx         = Y_CTR;
          serve_cnt_nx = '0;
          state_nx     = SERVE;
        end
        default: state_nx = SERVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    tick_prev <= tick_in;
    if (reset) begin
      state     <= SERVE;
      serve_cnt <= '0;
      ball_x    <= X_CTR;
      ball_y    <= Y_CTR;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      score_l   <= 1'b0;
      score_r   <= 1'b0;
    end else begin
      state     <= state_nx;
      serve_cnt <= serve_cnt_nx;
      ball_x    <= x_nx;
      ball_y    <= y_nx;
      dir_x     <= dx_nx;
      dir_y     <= dy_nx;
      score_l   <= sl_nx;
      score_r   <= sr_nx;
    end
  end

endmodule

// File: doc/ball_motion.md
# ball_motion

Ball-position engine for the pong datapath. It consumes the slow square-wave tick produced by the clock divider and converts each rising edge into a single-cycle step. Each step advances a ball across a discrete XBITS×YBITS playfield, bouncing it off the top/bottom walls and the two paddles. It reports misses as one-cycle score pulses to the score logic and exports the ball position to the video renderer.

## Interface
- XBITS, 5, width of ball_x; columns 0..2^XBITS-1
- YBITS, 4, width of ball_y; rows 0..2^YBITS-1
- PADDLE_H, 3, paddle height in rows
- SERVE_DELAY, 8, steps spent in SERVE before play starts (≥1)

- clk  input  1  system clock, same domain as the divider
- reset  input  1  synchronous, active-high; clock clk
- tick_in  input  1  level from clock divider output; each rising edge is one step
- paddle_l  input  YBITS  top row of left paddle (column 0)
- paddle_r  input  YBITS  top row of right paddle (column 2^XBITS-1)
- ball_x  output  XBITS  ball column, registered
- ball_y  output  YBITS  ball row, registered
- dir_x  output  1  1 = moving right, 0 = left
- dir_y  output  1  1 = moving down (increasing y), 0 = up
- score_l  output  1  one-cycle pulse: left player scored
- score_r  output  1  one-cycle pulse: right player scored

## Operation
- Edge detect: tick_prev <= tick_in every cycle, including during reset (loaded, not cleared), so a high tick_in at reset release produces no step. step = tick_in & ~tick_prev. No synchronizer; same clock domain.
- Reset values: ball_x = 2^(XBITS-1) (16), ball_y = 2^(YBITS-1) (8), dir_x = 1, dir_y = 1, score_l = score_r = 0, state SERVE, serve_cnt = 0.
- States: SERVE, PLAY, MISS.
- SERVE: ball parked at centre. Each step increments serve_cnt. The step where serve_cnt == SERVE_DELAY-1 moves to PLAY with no motion on that step.
- PLAY, per step. Vertical and horizontal rules use pre-step ball_y.
  - Vertical: if dir_y=1 and y==max, set dir_y=0 and y=max-1. If dir_y=0 and y==0, set dir_y=1 and y=1. Otherwise y±1.
  - Horizontal, dir_x=0 and x==1: hit iff paddle_l ≤ y < paddle_l+PADDLE_H, computed at YBITS+1 bits (no wrap).
    - Hit: dir_x=1, x=2.
    - Miss: x=0, score_r pulse, go to MISS.
  - Horizontal, dir_x=1 and x==max-1: mirror of the left case using paddle_r. Miss gives x=max, score_l pulse, go to MISS.
  - Horizontal, otherwise: x±1.
- MISS: ball frozen at the edge column for the rest of that step interval. On the next step: recentre, serve_cnt=0, go to SERVE. dir_x is set toward the conceding side (left conceded gives dir_x=0); dir_y is kept.
- Paddle inputs are sampled only on step cycles; they may change freely otherwise.

## Timing
- The step cycle is the first clk cycle with tick_in=1 after tick_in=0. Registered outputs update at the end of that cycle, so they are visible one cycle after tick_in rises.
- score_l/score_r are high for exactly one clk cycle, the cycle after the miss step, and never both high.
- tick_in held high for any duration produces exactly one step.
- With SERVE_DELAY=8, the first ball motion occurs on the 9th step after reset.
- Reset mid-operation, in any state, takes effect on the next clk edge. It restores all reset values and aborts any pending score pulse.

## Configuration
- BALL_MOTION_PAUSE_EN
  - Defined: adds input port pause (1 bit, after paddle_r). While pause=1, steps are ignored: state, position, direction and serve_cnt are frozen and no score pulse is issued. Edge detection continues, so no burst of steps occurs on release.
  - Undefined: no pause port; every step is acted on.

## Test plan
- Reset, then 8 tick rising edges → ball stays (16,8) in SERVE. 9th edge → (17,9), dir_x=1, dir_y=1.
- Ball at y=15, dir_y=1, step → y=14, dir_y=0. At y=0, dir_y=0, step → y=1, dir_y=1.
- Ball at x=1, dir_x=0, y=5, paddle_l=4 → x=2, dir_x=1, no score pulse. Same with paddle_l=3 → hit (y=5 is the last paddle row); paddle_l=6 → miss.
- Miss on left (y=5, paddle_l=10) → x=0, score_r=1 for one cycle. Next step → (16,8), dir_x=0, SERVE. tick_in held high 20 cycles → only one step.
- Assert reset for one cycle mid-PLAY at (20,3) → next cycle (16,8), dir=(1,1), scores 0. Reset with tick_in=1 and release → no step until tick_in falls and rises.
- With BALL_MOTION_PAUSE_EN: pause=1 across 5 tick edges → position unchanged. Release pause → next edge advances exactly one position.
